// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide on magnitudes.
// Define MDU_DIV_EN to build the divider; otherwise DIV*/REM* complete through the fast path with result 0.
module mdu_iter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rd1_i,
  input  logic [31:0] rd2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] acc, acc_step;
  logic [31:0] mag_b;
  logic [5:0]  cnt;
  logic        neg_a, neg_b, mul_hi_sel, hold;
  logic        a_sgn, b_sgn, sa, sb, fast;
  logic [31:0] abs_a, abs_b, fast_res, fix_res;
  logic [32:0] mul_sum;
  logic [63:0] prod_s;
`ifdef MDU_DIV_EN
  logic        is_div, is_rem, div_zero, div_ovf, div_ge;
  logic [32:0] div_shift;
`endif

  always_comb begin
    a_sgn = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
            (funct3_i == 3'b100) || (funct3_i == 3'b110);
    b_sgn = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    sa    = a_sgn & rd1_i[31];
    sb    = b_sgn & rd2_i[31];
    abs_a = sa ? -rd1_i : rd1_i;
    abs_b = sb ? -rd2_i : rd2_i;
`ifdef MDU_DIV_EN
    div_zero = (rd2_i == '0);
    div_ovf  = !funct3_i[0] && (rd1_i == 32'h8000_0000) && (rd2_i == '1);
    fast     = funct3_i[2] && (div_zero || div_ovf);
    if (div_zero) fast_res = funct3_i[1] ? rd1_i : '1;
    else          fast_res = funct3_i[1] ? '0 : 32'h8000_0000;
`else
    fast     = funct3_i[2];
    fast_res = '0;
`endif
  end

  // acc holds {partial product hi, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = acc[0] ? {1'b0, acc[63:32]} + {1'b0, mag_b} : {1'b0, acc[63:32]};
    acc_step = {mul_sum, acc[31:1]};
`ifdef MDU_DIV_EN
    div_shift = {acc[63:32], acc[31]};
    div_ge    = div_shift >= {1'b0, mag_b};
    if (is_div)
      acc_step = {(div_ge ? div_shift[31:0] - mag_b : div_shift[31:0]), acc[30:0], div_ge};
`endif
  end

  always_comb begin
    prod_s  = (neg_a ^ neg_b) ? -acc : acc;
    fix_res = mul_hi_sel ? prod_s[63:32] : prod_s[31:0];
`ifdef MDU_DIV_EN
    if (is_div) begin
      if (is_rem) fix_res = neg_a ? -acc[63:32] : acc[63:32];
      else        fix_res = (neg_a ^ neg_b) ? -acc[31:0] : acc[31:0];
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_i) state_next = fast ? DONE : CALC;
      CALC: if (cnt == 6'd31) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (!hold) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill_i) state_next = IDLE;
  end

  assign busy_o = (state == CALC) || (state == FIX);
  // The fast path spends one silent cycle in DONE so its pulse lands one cycle after acceptance.
  assign done_o = (state == DONE) && !hold;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc        <= '0;
      mag_b      <= '0;
      cnt        <= '0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      mul_hi_sel <= 1'b0;
      hold       <= 1'b0;
      result_o   <= '0;
`ifdef MDU_DIV_EN
      is_div     <= 1'b0;
      is_rem     <= 1'b0;
`endif
    end else if (kill_i) begin
      hold <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          acc        <= {32'h0, abs_a};
          mag_b      <= abs_b;
          cnt        <= '0;
          neg_a      <= sa;
          neg_b      <= sb;
          mul_hi_sel <= (funct3_i[1:0] != 2'b00);
`ifdef MDU_DIV_EN
          is_div     <= funct3_i[2];
          is_rem     <= funct3_i[1];
`endif
          if (fast) begin
            result_o <= fast_res;
            hold     <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
        end
        FIX:  result_o <= fix_res;
        DONE: hold <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed RV32M corner cases plus randomized ops against an arithmetic model.
module tb_mdu_iter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rd1_i = '0;
  logic [31:0] rd2_i = '0;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  always #5 clk_i = ~clk_i;

  mdu_iter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .kill_i(kill_i),
    .funct3_i(funct3_i), .rd1_i(rd1_i), .rd2_i(rd2_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
    int unsigned busy;
  } exp_t;

  exp_t        scoreboard[$];
  int unsigned cyc = 0;
  int unsigned busy_run = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_exp = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (rst_ni && done_o) begin
      if (scoreboard.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done_o=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = scoreboard.pop_front();
        check("result", result_o, e.res);
        check("done_cycle", cyc, e.cyc);
        check("busy_cycles", busy_run, e.busy);
      end
      busy_run = 0;
    end else if (busy_o) busy_run++;
    else busy_run = 0;
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint av, bv, p;
    av = (f == 3'b001 || f == 3'b010) ? longint'($signed(a)) : longint'({32'h0, a});
    bv = (f == 3'b001) ? longint'($signed(b)) : longint'({32'h0, b});
    p  = av * bv;
    if (!f[2]) return (f == 3'b000) ? p[31:0] : p[63:32];
`ifdef MDU_DIV_EN
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
      return f[1] ? sa % sb : sa / sb;
    end
    return f[1] ? a % b : a / b;
`else
    return '0;
`endif
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_DIV_EN
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
    return f[2] && (a == a) && (b == b);
`endif
  endfunction

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input bit fast);
    exp_t e;
    funct3_i = f; rd1_i = a; rd2_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    e.res  = res;
    e.cyc  = cyc + (fast ? 1 : 33);
    e.busy = fast ? 0 : 33;
    scoreboard.push_back(e);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk_i); #1;
      if (scoreboard.size() == 0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", scoreboard.size());
      scoreboard.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input bit fast);
    launch(f, a, b, res, fast);
    drain();
    last_exp = res;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    exp_t        e;

    #2 rst_ni = 1'b0;
    #3;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_result", result_o, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    run(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 0);
    run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`ifdef MDU_DIV_EN
    run(3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 0);
    run(3'b110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 0);
    run(3'b101, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 0);
    run(3'b100, 32'h5, 32'h0, 32'hFFFF_FFFF, 1);
    run(3'b110, 32'h5, 32'h0, 32'h5, 1);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
`else
    run(3'b101, 32'h9, 32'h3, 32'h0, 1);
    run(3'b100, 32'h5, 32'h0, 32'h0, 1);
`endif

    // kill in the middle of a multiply: no pulse, result untouched
    funct3_i = 3'b000; rd1_i = 32'h1234; rd2_i = 32'h5678; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    kill_i = 1'b1;
    @(posedge clk_i); #1; kill_i = 1'b0;
    check("kill_busy", busy_o, 0);
    repeat (40) @(negedge clk_i);
    check("kill_result", result_o, last_exp);

    // start held through CALC must not queue a second operation
    funct3_i = 3'b000; rd1_i = 32'd3; rd2_i = 32'd5; start_i = 1'b1;
    @(posedge clk_i); #1;
    e.res = 32'd15; e.cyc = cyc + 33; e.busy = 33;
    scoreboard.push_back(e);
    repeat (20) @(negedge clk_i);
    check("held_start_busy", busy_o, 1);
    start_i = 1'b0;
    drain();
    last_exp = 32'd15;
    repeat (40) @(negedge clk_i);

    // kill beats start in the same cycle
    funct3_i = 3'b000; rd1_i = 32'd7; rd2_i = 32'd7; start_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; kill_i = 1'b0;
    check("kill_priority_busy", busy_o, 0);
    repeat (40) @(negedge clk_i);
    check("kill_priority_result", result_o, last_exp);

    // reset in the middle of a long operation
`ifdef MDU_DIV_EN
    funct3_i = 3'b100; rd1_i = 32'd100; rd2_i = 32'd7;
`else
    funct3_i = 3'b000; rd1_i = 32'd100; rd2_i = 32'd7;
`endif
    start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (19) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("midop_reset_busy", busy_o, 0);
    check("midop_reset_done", done_o, 0);
    check("midop_reset_result", result_o, 32'h0);
    last_exp = 32'h0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    run(3'b000, 32'd6, 32'd7, 32'd42, 0);

    for (int n = 0; n < 150; n++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run(f, a, b, model(f, a, b), is_fast(f, a, b));
    end

    repeat (5) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
